image_frame_scheduler: RTL and testbench

- Schedules image display in the clk_pixel domain. It sits between the command/timestamp source and ImageSender.
- It holds a small queue of timestamped display commands. Each command is started on the first frame boundary after the global counter reaches the command's timestamp, and is held for a programmed number of frames.
- It drives image advance, display gating and flush toward ImageSender, and reports underrun and late-start conditions.

---
 rtl/image_frame_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_image_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_scheduler.sv
// rtl/image_frame_scheduler.sv - timestamped image display scheduler in front of ImageSender
//
// Purpose: queues timestamped display commands, starts each on the first frame
// boundary after the global counter reaches its timestamp, holds it for a
// programmed number of frames, and drives advance/gating/flush toward ImageSender.
//
// Ports:
//   clk_pixel, reset           clock, asynchronous active-high reset
//   auto_start                 run enable; falling edge flushes
//   counter                    global 64-bit timestamp (clk_pixel domain)
//   cmd_valid/cmd_ready        command push handshake
//   cmd_time, cmd_frames       command start timestamp and frame count (0 means 1)
//   cx, cy                     current pixel position, (0,0) marks frame start
//   image_sender_empty         ImageSender FIFO empty
//   image_advance              one-cycle pulse: start next image
//   display_en                 show ImageSender rgb when high
//   image_sender_flush         flush ImageSender FIFO
//   frame_count                frames completed for active command (saturating)
//   queue_level                number of queued commands
//   busy, underrun, late       not idle, sticky underrun, sticky late start
module image_frame_scheduler #(
    parameter int BIT_WIDTH       = 12,
    parameter int BIT_HEIGHT      = 11,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int QUEUE_DEPTH     = 4,
    parameter int FLUSH_CYCLES    = 4
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic                         auto_start,
    input  logic [63:0]                  counter,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [63:0]                  cmd_time,
    input  logic [FRAME_CNT_WIDTH-1:0]   cmd_frames,
    input  logic [BIT_WIDTH-1:0]         cx,
    input  logic [BIT_HEIGHT-1:0]        cy,
    input  logic                         image_sender_empty,
    output logic                         image_advance,
    output logic                         display_en,
    output logic                         image_sender_flush,
    output logic [FRAME_CNT_WIDTH-1:0]   frame_count,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level,
    output logic                         busy,
    output logic                         underrun,
    output logic                         late
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(QUEUE_DEPTH);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [FRAME_CNT_WIDTH-1:0] ONE_FRAME = FRAME_CNT_WIDTH'(1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_TIME  = 3'd1;
    localparam logic [2:0] S_WAIT_FRAME = 3'd2;
    localparam logic [2:0] S_DISPLAY    = 3'd3;
    localparam logic [2:0] S_FLUSH      = 3'd4;

    logic [63:0]                mem_time   [QUEUE_DEPTH];
    logic [FRAME_CNT_WIDTH-1:0] mem_frames [QUEUE_DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [2:0]                 state;
    logic                       fs_raw, fs_raw_q, fs_p;
    logic                       auto_q, fall, wait_first;
    logic [63:0]                act_time, head_time;
    logic [FRAME_CNT_WIDTH-1:0] frames_left, head_frames, load_frames, frame_inc;
    logic [FW-1:0]              flush_cnt;
    logic                       push, q_empty, head_due, last_frame, do_load;

    assign fs_raw      = (cx == '0) && (cy == '0);
    assign fall        = auto_q && !auto_start;
    assign cmd_ready   = (queue_level != LEVEL_FULL) && (state != S_FLUSH);
    assign busy        = (state != S_IDLE);
    assign push        = cmd_valid && cmd_ready;
    assign q_empty     = (queue_level == '0);
    assign head_time   = mem_time[rd_ptr];
    assign head_frames = mem_frames[rd_ptr];
    assign head_due    = (counter >= head_time);
    assign last_frame  = (frames_left <= ONE_FRAME);
    assign load_frames = (head_frames == '0) ? ONE_FRAME : head_frames;
    assign frame_inc   = (&frame_count) ? frame_count : frame_count + ONE_FRAME;

    // Pop the head either to start from idle or when the active command's
    // last frame ends and another command is waiting. A flush wins over both.
    assign do_load = !fall && !q_empty &&
                     ((state == S_IDLE && auto_start) ||
                      (state == S_DISPLAY && fs_p && last_frame));

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem_time[wr_ptr]   <= cmd_time;
            mem_frames[wr_ptr] <= cmd_frames;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            fs_raw_q           <= 1'b0;
            fs_p               <= 1'b0;
            auto_q             <= 1'b0;
            wait_first         <= 1'b0;
            act_time           <= '0;
            frames_left        <= '0;
            flush_cnt          <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            queue_level        <= '0;
            image_advance      <= 1'b0;
            display_en         <= 1'b0;
            image_sender_flush <= 1'b0;
            frame_count        <= '0;
            underrun           <= 1'b0;
            late               <= 1'b0;
        end else begin
            fs_raw_q      <= fs_raw;
            fs_p          <= fs_raw && !fs_raw_q;
            auto_q        <= auto_start;
            image_advance <= 1'b0;

            if (fall) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                queue_level <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (do_load)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, do_load})
                    2'b10:   queue_level <= queue_level + LW'(1);
                    2'b01:   queue_level <= queue_level - LW'(1);
                    default: queue_level <= queue_level;
                endcase
            end

            if (fall) begin
                state              <= S_FLUSH;
                image_sender_flush <= 1'b1;
                flush_cnt          <= FLUSH_LAST;
                display_en         <= 1'b0;
                wait_first         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        display_en <= 1'b0;
                        if (do_load) begin
                            state      <= S_WAIT_TIME;
                            wait_first <= 1'b1;
                        end
                    end
                    S_WAIT_TIME: begin
                        display_en <= 1'b0;
                        wait_first <= 1'b0;
                        // Lateness is judged only on arrival; later cycles are just waiting.
                        if (wait_first && counter > act_time)
                            late <= 1'b1;
                        if (counter >= act_time)
                            state <= S_WAIT_FRAME;
                    end
                    S_WAIT_FRAME: begin
                        if (fs_p) begin
                            image_advance <= 1'b1;
                            display_en    <= 1'b1;
                            state         <= S_DISPLAY;
                            if (image_sender_empty)
                                underrun <= 1'b1;
                        end
                    end
                    S_DISPLAY: begin
                        if (fs_p) begin
                            frame_count <= frame_inc;
                            if (!last_frame) begin
                                frames_left <= frames_left - ONE_FRAME;
                            end else if (do_load && head_due) begin
                                // Back-to-back: next image starts on this boundary, no black frame.
                                image_advance <= 1'b1;
                                if (image_sender_empty)
                                    underrun <= 1'b1;
                            end else if (do_load) begin
                                display_en <= 1'b0;
                                state      <= S_WAIT_TIME;
                                wait_first <= 1'b1;
                            end else begin
                                display_en <= 1'b0;
                                state      <= S_IDLE;
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (flush_cnt == '0) begin
                            image_sender_flush <= 1'b0;
                            state              <= S_IDLE;
                        end else begin
                            flush_cnt <= flush_cnt - FW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end

            // Placed last so a load overrides the frame_count increment above.
            if (do_load) begin
                act_time    <= head_time;
                frames_left <= load_frames;
                frame_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_image_frame_scheduler.sv
// tb/tb_image_frame_scheduler.sv - self-checking bench for image_frame_scheduler
module tb_image_frame_scheduler;

    localparam int FP = 16;   // cycles per frame: 8 x 2 pixels

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        auto_start = 1'b0;
    logic [63:0] counter = 64'd1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_time = '0;
    logic [15:0] cmd_frames = '0;
    logic [11:0] cx = 12'd1;
    logic [10:0] cy = '0;
    logic        image_sender_empty = 1'b0;
    logic        image_advance, display_en, image_sender_flush;
    logic [15:0] frame_count;
    logic [2:0]  queue_level;
    logic        busy, underrun, late;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int sc_off[$];
    int sc_frm[$];
    bit exp_adv[int];
    bit exp_den[int];

    image_frame_scheduler dut (
        .clk_pixel(clk_pixel), .reset(reset), .auto_start(auto_start), .counter(counter),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_time(cmd_time), .cmd_frames(cmd_frames),
        .cx(cx), .cy(cy), .image_sender_empty(image_sender_empty),
        .image_advance(image_advance), .display_en(display_en), .image_sender_flush(image_sender_flush),
        .frame_count(frame_count), .queue_level(queue_level), .busy(busy),
        .underrun(underrun), .late(late)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; afterwards cyc is the index of the edge just taken.
    // The counter sampled at edge e equals e, and (0,0) is sampled at edges e%FP==0.
    task automatic step();
        int pos;
        @(posedge clk_pixel);
        #1;
        cyc++;
        pos     = (cyc + 1) % FP;
        counter = 64'(cyc + 1);
        cx      = 12'(pos % 8);
        cy      = 11'(pos / 8);
    endtask

    task automatic do_reset();
        cmd_valid  = 1'b0;
        auto_start = 1'b0;
        reset      = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Runs the queued commands (offsets relative to the first push edge) and
    // predicts every output from frame arithmetic: a command that must wait
    // starts at the first frame action edge (e%FP==1) after its time is met,
    // and a due successor starts exactly when the previous one ends.
    task automatic run_scn(input bit empty);
        int P, L, A, E, w, n, T, last, late_e, first_adv, nlast, ncmd, idx, tq;
        bit wait_path;
        do_reset();
        image_sender_empty = empty;
        auto_start = 1'b1;
        P = cyc + 1;
        ncmd = sc_off.size();
        exp_adv.delete();
        exp_den.delete();
        late_e = -1; first_adv = -1; L = P + 1; wait_path = 1'b1; E = 0; nlast = 0;
        for (int i = 0; i < ncmd; i++) begin
            T = (P + sc_off[i] < 0) ? 0 : P + sc_off[i];
            n = (sc_frm[i] == 0) ? 1 : sc_frm[i];
            if (wait_path) begin
                if (L + 1 > T && late_e < 0) late_e = L + 1;
                w = (L + 1 > T) ? L + 1 : T;
                A = w + 1;
                while (A % FP != 1) A++;
            end else begin
                A = E;
            end
            exp_adv[A] = 1'b1;
            if (first_adv < 0) first_adv = A;
            E = A + n * FP;
            for (int e = A; e < E; e++) exp_den[e] = 1'b1;
            nlast = n;
            if (i + 1 < ncmd) begin
                tq = (P + sc_off[i+1] < 0) ? 0 : P + sc_off[i+1];
                wait_path = (tq > E);
                L = E;
            end
        end
        last = E;
        while (cyc < last + 4) begin
            idx = cyc + 1 - P;
            if (idx >= 0 && idx < ncmd) begin
                cmd_valid  = 1'b1;
                cmd_time   = 64'((P + sc_off[idx] < 0) ? 0 : P + sc_off[idx]);
                cmd_frames = 16'(sc_frm[idx]);
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            chk("advance", image_advance, exp_adv.exists(cyc));
            chk("display_en", display_en, exp_den.exists(cyc));
            chk("busy", busy, (cyc >= P + 1 && cyc < last));
            chk("underrun", underrun, (empty && cyc >= first_adv));
            chk("late", late, (late_e >= 0 && cyc >= late_e));
            chk("flush_idle", image_sender_flush, 0);
        end
        chk("frame_count_end", frame_count, nlast);
        chk("queue_level_end", queue_level, 0);
        sc_off.delete();
        sc_frm.delete();
    endtask

    initial begin
        int nfl, ncmd_r;
        #1;
        chk("rst_advance", image_advance, 0);
        chk("rst_display_en", display_en, 0);
        chk("rst_flush", image_sender_flush, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_queue_level", queue_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_late", late, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) step();

        // Timed start, future timestamp, two frames.
        sc_off.push_back(500); sc_frm.push_back(2);
        run_scn(1'b0);
        // Back-to-back with past timestamps: late, no black frame.
        sc_off.push_back(-100); sc_frm.push_back(1);
        sc_off.push_back(-100); sc_frm.push_back(3);
        run_scn(1'b0);
        // Timestamp 0, zero frames, ImageSender empty.
        sc_off.push_back(-1000000); sc_frm.push_back(0);
        run_scn(1'b1);
        // Randomized command sets.
        for (int r = 0; r < 6; r++) begin
            ncmd_r = $urandom_range(1, 3);
            for (int i = 0; i < ncmd_r; i++) begin
                sc_off.push_back($urandom_range(0, 120) - 60);
                sc_frm.push_back($urandom_range(0, 3));
            end
            run_scn(1'($urandom_range(0, 1)));
        end

        // Queue full with auto_start low.
        do_reset();
        image_sender_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_time = '0; cmd_frames = 16'd3;
            step();
            chk("qfull_level", queue_level, (i + 1 < 4) ? i + 1 : 4);
            chk("qfull_ready", cmd_ready, (i + 1 < 4));
        end
        auto_start = 1'b1;
        step();
        chk("pop_level", queue_level, 3);
        chk("pop_ready", cmd_ready, 1);
        chk("pop_busy", busy, 1);
        step();
        chk("fifth_push_level", queue_level, 4);
        cmd_valid = 1'b0;

        // Flush from DISPLAY.
        for (int k = 0; k < 40 && !display_en; k++) step();
        chk("reach_display", display_en, 1);
        auto_start = 1'b0;
        nfl = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (image_sender_flush) nfl++;
            if (k == 0) begin
                chk("flush_level", queue_level, 0);
                chk("flush_display_en", display_en, 0);
                chk("flush_busy", busy, 1);
                chk("flush_ready", cmd_ready, 0);
            end
        end
        chk("flush_cycles", nfl, 4);
        chk("flush_done_busy", busy, 0);
        chk("flush_done_flush", image_sender_flush, 0);

        // Asynchronous reset while waiting for a frame boundary.
        auto_start = 1'b1;
        for (int k = 0; k < 16 && (cyc % FP) != 2; k++) step();
        cmd_valid = 1'b1; cmd_time = '0; cmd_frames = 16'd1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("wf_busy", busy, 1);
        chk("wf_display_en", display_en, 0);
        chk("wf_late", late, 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_late", late, 0);
        chk("arst_frame_count", frame_count, 0);
        chk("arst_level", queue_level, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_display_en", display_en, 0);
        chk("arst_advance", image_advance, 0);
        chk("arst_flush", image_sender_flush, 0);
        nfl = 0;
        step();
        if (image_sender_flush) nfl++;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (image_sender_flush) nfl++;
        end
        chk("arst_no_flush", nfl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
